// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for NUM_DIGITS seven-segment digits that
// share one nibble decoder. A display word is held in an "active" register
// and the digits are driven one slot at a time, with optional blanking gaps
// between slots. New words arrive over a valid/ready handshake and are only
// swapped into the active register on a frame boundary (or while idle), so
// a frame never mixes digits of two words.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = scan, 0 = go idle and blank
//   blank_lz    1 = blank leading zeros (digit 0 never blanked)
//   load_valid  load_data is valid
//   load_ready  controller can accept a word (registered)
//   load_data   display word, digit i = load_data[4i+3:4i]
//   nib_out     nibble to the shared decoder (bit3 = w ... bit0 = z)
//   dig_sel     one-hot active-high digit enable
//   blank       1 = decoder output forced off
//   frame_done  one-cycle pulse after the last digit slot of a frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              nib_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int DW      = 4 * NUM_DIGITS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] SCAN_TC  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [DW-1:0]         active_q,     active_d;
    logic [DW-1:0]         pending_q,    pending_d;
    logic                  pend_vld_q,   pend_vld_d;
    logic                  load_ready_q, load_ready_d;
    logic [3:0]            nib_out_q,    nib_out_d;
    logic [NUM_DIGITS-1:0] dig_sel_q,    dig_sel_d;
    logic                  blank_q,      blank_d;
    logic                  frame_done_q, frame_done_d;

    logic                  xfer_s;
    logic                  boundary_s;

    // Digit index following i, wrapping after the most significant digit.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] n;
        if (i == LAST_IDX) begin
            n = IDX_ZERO;
        end else begin
            n = i + IDX_W'(1);
        end
        return n;
    endfunction

    // Nibble of digit i within a display word.
    function automatic logic [3:0] nibble_at(input logic [DW-1:0] w, input logic [IDX_W-1:0] i);
        logic [3:0] n;
        n = 4'h0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == i) begin
                n = w[4*j +: 4];
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Leading-zero blank: digit i and every more significant digit are zero.
    function automatic logic lz_blank(input logic [DW-1:0] w, input logic [IDX_W-1:0] i,
                                      input logic blz);
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= i) && (w[4*j +: 4] != 4'h0)) begin
                nz = 1'b1;
            end else begin
                nz = nz;
            end
        end
        return blz && (i != IDX_ZERO) && !nz;
    endfunction

    assign xfer_s     = load_valid && load_ready_q;
    // Last cycle of the last digit slot; the edge ending it is where words swap.
    assign boundary_s = (state_q == ST_SCAN) && (cnt_q == SCAN_TC) && (idx_q == LAST_IDX);

    // Next-state, word-buffer and output computation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        frame_done_d = 1'b0;
        nib_out_d    = nib_out_q;
        dig_sel_d    = '0;
        blank_d      = 1'b1;

        // Scan sequencing
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SCAN;
                    idx_d   = IDX_ZERO;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_ZERO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == SCAN_TC) begin
                    cnt_d = CNT_ZERO;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        idx_d = next_idx(idx_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_ZERO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == GAP_TC) begin
                    state_d = ST_SCAN;
                    cnt_d   = CNT_ZERO;
                    idx_d   = next_idx(idx_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_ZERO;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Word handshake. A word accepted while idle, on the boundary edge, or
        // on the edge that drops to idle can go straight to active because no
        // partially shown frame exists to tear.
        if (state_q == ST_IDLE) begin
            if (xfer_s) begin
                active_d = load_data;
            end else begin
                active_d = active_q;
            end
        end else if (!enable || boundary_s) begin
            if (pend_vld_q) begin
                active_d   = pending_q;
                pending_d  = '0;
                pend_vld_d = 1'b0;
            end else if (xfer_s) begin
                active_d = load_data;
            end else begin
                active_d = active_q;
            end
            frame_done_d = boundary_s && enable;
        end else if (xfer_s) begin
            pending_d  = load_data;
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end

        load_ready_d = !pend_vld_d;

        // Outputs follow the state being entered so they line up with it.
        case (state_d)
            ST_SCAN: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    dig_sel_d[i] = (IDX_W'(i) == idx_d);
                end
                nib_out_d = nibble_at(active_d, idx_d);
                blank_d   = lz_blank(active_d, idx_d, blank_lz);
            end
            ST_GAP: begin
                nib_out_d = nib_out_q;
            end
            ST_IDLE: begin
                nib_out_d = 4'h0;
            end
            default: begin
                nib_out_d = 4'h0;
            end
        endcase
    end

    // State, word buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= IDX_ZERO;
            cnt_q        <= CNT_ZERO;
            active_q     <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            load_ready_q <= 1'b1;
            nib_out_q    <= 4'h0;
            dig_sel_q    <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            load_ready_q <= load_ready_d;
            nib_out_q    <= nib_out_d;
            dig_sel_q    <= dig_sel_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign nib_out    = nib_out_q;
    assign dig_sel    = dig_sel_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4,
// GAP_CYCLES=1 (20-cycle frame). Expected per-cycle outputs are pushed into a
// queue as stimulus is planned and popped one per clock for comparison.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        blank_lz;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  nib_out;
    logic [3:0]  dig_sel;
    logic        blank;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] dig;
        logic [3:0] nib;
        logic       blk;
        logic       fd;
        logic       lr;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks;
    int    n_fail;
    string cur_tag;
    int    step_no;

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .GAP_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .nib_out   (nib_out),
        .dig_sel   (dig_sel),
        .blank     (blank),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected idle / reset output pattern.
    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dig = 4'b0000;
            e.nib = 4'h0;
            e.blk = 1'b1;
            e.fd  = 1'b0;
            e.lr  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Expected outputs for the first `count` cycles of one 20-cycle frame of
    // `word`. load_ready is low from cycle `drop` up to the boundary cycle 18.
    task automatic push_frame(input logic [15:0] word, input logic blz,
                              input int drop, input int count);
        exp_t e;
        int   d;
        int   ph;
        for (int i = 0; i < count; i++) begin
            d  = i / 5;
            ph = i % 5;
            e.nib = word[4*d +: 4];
            if (ph < 4) begin
                e.dig = 4'b0001 << d;
                e.blk = blz && (d != 0) && ((word >> (4*d)) == 16'h0000);
            end else begin
                e.dig = 4'b0000;
                e.blk = 1'b1;
            end
            e.fd = (i == 19);
            e.lr = !((i >= drop) && (i <= 18));
            exp_q.push_back(e);
        end
    endtask

    // Pop one expectation and compare it with the current outputs.
    task automatic check_now();
        exp_t e;
        exp_t o;
        o = '{dig: dig_sel, nib: nib_out, blk: blank, fd: frame_done, lr: load_ready};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s step %0d: no expectation queued", cur_tag, step_no);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s step %0d: observed dig=%b nib=%h blank=%b fd=%b rdy=%b expected dig=%b nib=%h blank=%b fd=%b rdy=%b",
                       cur_tag, step_no, o.dig, o.nib, o.blk, o.fd, o.lr,
                       e.dig, e.nib, e.blk, e.fd, e.lr);
            end
        end
        step_no++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        step_no    = 0;
        rst_n      = 1'b1;
        enable     = 1'b0;
        blank_lz   = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;

        // Reset state
        cur_tag = "reset";
        #1 rst_n = 1'b0;
        #2;
        push_idle(1);
        check_now();
        #19 rst_n = 1'b1;

        // Load in IDLE, then scan 1A3F
        cur_tag    = "idle_load";
        load_valid = 1'b1;
        load_data  = 16'h1A3F;
        push_idle(1);
        step_n(1);
        load_valid = 1'b0;
        enable     = 1'b1;
        cur_tag    = "frame_1a3f";
        push_frame(16'h1A3F, 1'b0, 99, 20);
        step_n(20);

        // Mid-frame load of 0042: held pending, frame keeps showing 1A3F
        cur_tag = "midframe_load";
        push_frame(16'h1A3F, 1'b0, 7, 20);
        step_n(7);
        load_valid = 1'b1;
        load_data  = 16'h0042;
        step_n(1);
        load_valid = 1'b0;
        load_data  = 16'hFFFF;
        step_n(12);
        cur_tag = "frame_0042";
        push_frame(16'h0042, 1'b0, 99, 20);
        step_n(20);

        // Leading-zero blanking of 0042, then load 0000 mid-frame
        cur_tag  = "lz_0042";
        blank_lz = 1'b1;
        push_frame(16'h0042, 1'b1, 2, 20);
        step_n(2);
        load_valid = 1'b1;
        load_data  = 16'h0000;
        step_n(1);
        load_valid = 1'b0;
        step_n(17);

        // 0000 with LZ; 5555 transferred in the boundary cycle itself
        cur_tag = "lz_0000";
        push_frame(16'h0000, 1'b1, 99, 20);
        step_n(19);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step_n(1);
        load_valid = 1'b0;

        // enable drops during digit-2 slot
        cur_tag = "frame_5555";
        push_frame(16'h5555, 1'b1, 99, 11);
        step_n(11);
        enable  = 1'b0;
        cur_tag = "disable";
        push_idle(3);
        step_n(3);
        enable  = 1'b1;
        cur_tag = "restart";
        push_frame(16'h5555, 1'b1, 99, 20);
        step_n(20);

        // Async reset mid-slot with a pending word
        cur_tag = "pre_reset";
        push_frame(16'h5555, 1'b1, 3, 8);
        step_n(3);
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step_n(1);
        load_valid = 1'b0;
        step_n(4);
        #2 rst_n = 1'b0;
        #1;
        cur_tag = "async_reset";
        push_idle(1);
        check_now();
        enable   = 1'b0;
        blank_lz = 1'b0;
        #2 rst_n = 1'b1;
        cur_tag = "post_reset_idle";
        push_idle(1);
        step_n(1);
        enable  = 1'b1;
        cur_tag = "post_reset_frame";
        push_frame(16'h0000, 1'b0, 99, 20);
        step_n(20);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d expectations unconsumed, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
